vc_test_rand_delay_source: RTL and testbench

VC_TEST_RAND_DELAY_SOURCE -- requirements
Module: vc_test_rand_delay_source

---
 rtl/vc_test_rand_delay_source_pkg.sv | 23 ++
 rtl/vc_test_rand_delay_lfsr.sv | 25 ++
 rtl/vc_test_rand_delay_source.sv | 92 +++++++++
 tb/tb_vc_test_rand_delay_source.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vc_test_rand_delay_source_pkg.sv
// Shared encodings for the random-delay test source: FSM states, LFSR taps,
// and (trace builds only) the val/rdy trace helper.
package vc_test_rand_delay_source_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SEND  = 2'd2
  } vc_state_e;

  localparam logic [31:0] VC_LFSR_TAPS = 32'h80200003;

`ifdef VC_TEST_RAND_DELAY_SOURCE_TRACE_EN
  // '#' = stalled, ' ' = idle with rdy, '.' = idle, otherwise the message text
  function automatic string vc_trace_valrdy(input logic val, input logic rdy, input string s);
    if (val && rdy)  return s;
    if (val && !rdy) return "#";
    if (!val && rdy) return " ";
    return ".";
  endfunction
`endif

endpackage

// File: rtl/vc_test_rand_delay_lfsr.sv
// 32-bit Galois LFSR plus modulo draw: delay = lfsr mod (max_delay + 1).
// The LFSR steps only when next is high, so every draw consumes one value.
module vc_test_rand_delay_lfsr
  import vc_test_rand_delay_source_pkg::*;
#(
  parameter logic [31:0] p_seed = 32'hB5AD4ECE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        next,
  input  logic [31:0] max_delay,
  output logic [31:0] delay
);

  logic [31:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     lfsr <= p_seed;
    else if (next) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? VC_LFSR_TAPS : 32'd0);
  end

  // 33-bit divisor so max_delay = all-ones still yields a nonzero modulus
  assign delay = 32'({1'b0, lfsr} % ({1'b0, max_delay} + 33'd1));

endmodule

// File: rtl/vc_test_rand_delay_source.sv
// Test source that streams m[0..] with a random 0..max_delay idle gap before
// each message. Define VC_TEST_RAND_DELAY_SOURCE_TRACE_EN for trace_module.
module vc_test_rand_delay_source
  import vc_test_rand_delay_source_pkg::*;
#(
  parameter int          p_msg_nbits = 1,
  parameter int          p_num_msgs  = 1024,
  parameter logic [31:0] p_seed      = 32'hB5AD4ECE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            max_delay,
  output logic                   val,
  input  logic                   rdy,
  output logic [p_msg_nbits-1:0] msg,
  output logic                   done
);

  localparam int IW = $clog2(p_num_msgs) + 1;
  localparam int AW = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;

  logic [p_msg_nbits-1:0] m [0:p_num_msgs-1];

  logic [IW-1:0]          index;
  logic [AW-1:0]          addr;
  logic [31:0]            count, count_next, delay;
  vc_state_e              state, state_next;
  logic                   in_range, xfer, draw;
  logic [p_msg_nbits-1:0] rd_msg;

  // Never index past the memory once every message has gone out
  assign in_range = index < IW'(p_num_msgs);
  assign addr     = AW'(index);
  assign rd_msg   = in_range ? m[addr] : '0;
  assign msg      = rd_msg;
  assign done     = !in_range || (rd_msg === {p_msg_nbits{1'bx}});

  assign val  = (state == ST_SEND) && !done;
  assign xfer = val && rdy;
  assign draw = (state == ST_INIT) || xfer;

  vc_test_rand_delay_lfsr #(.p_seed(p_seed)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .next     (draw),
    .max_delay(max_delay),
    .delay    (delay)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      ST_INIT, ST_SEND: begin
        if (draw) begin
          if (delay == 32'd0) state_next = ST_SEND;
          else begin
            state_next = ST_DELAY;
            count_next = delay;
          end
        end
      end
      ST_DELAY: begin
        count_next = count - 32'd1;
        if (count <= 32'd1) state_next = ST_SEND;
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      index <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (xfer) index <= index + 1'b1;
    end
  end

`ifdef VC_TEST_RAND_DELAY_SOURCE_TRACE_EN
  string msg_str;

  task trace_module(inout string trace_str);
    msg_str   = $sformatf("%x", msg);
    trace_str = {trace_str, vc_trace_valrdy(val, rdy, msg_str)};
  endtask
`endif

endmodule

// File: tb/tb_vc_test_rand_delay_source.sv
// Scoreboard bench for vc_test_rand_delay_source: three instances (16/8/4 deep),
// expected messages and LFSR-derived gaps queued at load, checked at transfer.
module tb_vc_test_rand_delay_source;

  localparam logic [31:0] SEED = 32'hB5AD4ECE;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  rdy = 3'b000;
  logic [2:0]  val, done;
  logic [31:0] md  [3];
  logic [7:0]  msg [3];

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  int gap_log[$];

  always #5 clk = ~clk;

  vc_test_rand_delay_source #(.p_msg_nbits(8), .p_num_msgs(16)) dut_a (
    .clk(clk), .reset(rst[0]), .max_delay(md[0]), .val(val[0]), .rdy(rdy[0]), .msg(msg[0]), .done(done[0]));
  vc_test_rand_delay_source #(.p_msg_nbits(8), .p_num_msgs(8)) dut_b (
    .clk(clk), .reset(rst[1]), .max_delay(md[1]), .val(val[1]), .rdy(rdy[1]), .msg(msg[1]), .done(done[1]));
  vc_test_rand_delay_source #(.p_msg_nbits(8), .p_num_msgs(4)) dut_c (
    .clk(clk), .reset(rst[2]), .max_delay(md[2]), .val(val[2]), .rdy(rdy[2]), .msg(msg[2]), .done(done[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  function automatic int get_index(input int inst);
    case (inst)
      0:       return int'(dut_a.index);
      1:       return int'(dut_b.index);
      default: return int'(dut_c.index);
    endcase
  endfunction

  task automatic load(input int inst, input int idx, input logic [7:0] v);
    case (inst)
      0:       dut_a.m[idx] = v;
      1:       dut_b.m[idx] = v;
      default: dut_c.m[idx] = v;
    endcase
  endtask

  task automatic do_reset(input int inst);
    rst[inst] = 1'b1;
    #1;
    chk("val_in_reset", val[inst], 1'b0);
    @(posedge clk); #1;
    chk("val_in_reset_edge", val[inst], 1'b0);
    chk("idx_in_reset", get_index(inst), 0);
    rst[inst] = 1'b0;
  endtask

  // Runs one stream; gaps are predicted from a software LFSR model.
  task automatic stream(input int inst, input logic [31:0] mdv, input int nmsg,
                        input int hold_idx, input int hold_n, input bit full);
    logic [31:0] s;
    int gap_q[$];
    int idle, sent, held, cyc, hi;
    longint d;
    s = SEED;
    for (int k = 0; k < nmsg; k++) begin
      d = longint'({32'd0, s}) % (longint'({32'd0, mdv}) + 64'sd1);
      gap_q.push_back((k == 0) ? int'(d) + 1 : int'(d));
      s = lfsr_step(s);
    end
    gap_log.delete();
    md[inst]  = mdv;
    rdy[inst] = 1'b1;
    do_reset(inst);
    chk("done_at_start", done[inst], 1'b0);
    idle = 0; sent = 0; held = 0; cyc = 0;
    while (sent < nmsg && cyc < 500) begin
      if (val[inst]) begin
        if (idle >= 0) begin
          gap_log.push_back(idle);
          if (gap_q.size() > 0) chk("gap", idle, gap_q.pop_front());
          idle = -1;
        end
        if (sent == hold_idx && held < hold_n) begin
          chk("hold_msg", msg[inst], exp_q[0]);
          chk("hold_idx", get_index(inst), sent);
          rdy[inst] = 1'b0;
          held++;
        end else begin
          rdy[inst] = 1'b1;
          if (exp_q.size() == 0) chk("extra_msg", 1, 0);
          else chk("msg", msg[inst], exp_q.pop_front());
          sent++;
          idle = 0;
        end
      end else begin
        if (idle >= 0) idle++;
        rdy[inst] = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("sent_count", sent, nmsg);
    if (full) begin
      chk("done", done[inst], 1'b1);
      hi = 0;
      for (int i = 0; i < 12; i++) begin
        rdy[inst] = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        hi += int'(val[inst]);
      end
      chk("val_after_done", hi, 0);
      chk("done_held", done[inst], 1'b1);
      chk("left_in_queue", exp_q.size(), 0);
    end
  endtask

  initial begin
    int run1[$];
    int maxg, nb;
    logic [7:0] v, xv;
    bit four_state;
    for (int i = 0; i < 3; i++) md[i] = 32'd0;
    xv = 'x;
    four_state = $isunknown(xv);
    repeat (2) @(posedge clk);
    #1;

    // Four messages, zero delay: back-to-back from cycle 1, done at cycle 5
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      v = 8'(17 * (i + 1));
      load(2, i, v);
      exp_q.push_back(v);
    end
    stream(2, 32'd0, 4, -1, 0, 1'b1);

    // Backpressure for three cycles on 8'h22
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(17 * (i + 1)));
    stream(2, 32'd0, 4, 1, 3, 1'b1);

    // Full 4-deep memory with random gaps; index ends one past the last entry
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(17 * (i + 1)));
    stream(2, 32'd2, 4, -1, 0, 1'b1);
    chk("oob_msg_known", $isunknown(msg[2]), 1'b0);

    // 16 messages, max_delay 3, run twice
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      v = 8'(13 * i + 5);
      load(0, i, v);
      exp_q.push_back(v);
    end
    stream(0, 32'd3, 16, -1, 0, 1'b1);
    run1 = gap_log;
    maxg = 0;
    for (int i = 1; i < run1.size(); i++) if (run1[i] > maxg) maxg = run1[i];
    chk("gap_range", maxg <= 3, 1'b1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(13 * i + 5));
    stream(0, 32'd3, 16, -1, 0, 1'b1);
    chk("repeat_len", gap_log.size(), run1.size());
    for (int i = 0; i < run1.size() && i < gap_log.size(); i++) chk("repeat_gap", gap_log[i], run1[i]);

    // Reset after two transfers: restart from m[0] with the same gaps
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(13 * i + 5));
    stream(0, 32'd3, 2, -1, 0, 1'b0);
    run1 = gap_log;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(13 * i + 5));
    stream(0, 32'd3, 16, -1, 0, 1'b1);
    for (int i = 0; i < 2; i++) chk("reset_gap", gap_log[i], run1[i]);

    // 8-deep memory, three loaded, rest all-X end sentinel
    exp_q.delete();
    load(1, 0, 8'h5A); load(1, 1, 8'hA5); load(1, 2, 8'h3C);
    for (int i = 3; i < 8; i++) load(1, i, xv);
    nb = four_state ? 3 : 8;
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    for (int i = 3; i < nb; i++) exp_q.push_back(xv);
    stream(1, 32'd1, nb, -1, 0, 1'b1);

    // All-ones max_delay: modulus 2^32 returns the seed untouched
    md[0] = 32'hFFFFFFFF;
    do_reset(0);
    chk("max_delay_all_ones", dut_a.u_lfsr.delay, SEED);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
